// File: rtl/wdg_pkg.sv
// rtl/wdg_pkg.sv - shared watchdog state encoding
package wdg_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_S1TO = 2'd2,
    ST_S2TO = 2'd3
  } wdg_state_e;

  // Prescaler runs only while a stage timer is counting
  function automatic logic is_counting(input wdg_state_e s);
    return (s == ST_RUN) || (s == ST_S1TO);
  endfunction

endpackage

// File: rtl/wdg_presc.sv
// rtl/wdg_presc.sv - free-running prescaler producing one-cycle ticks
module wdg_presc #(
  parameter int PRESC_WIDTH = 20,
  parameter int TICK_BIT    = 2
) (
  input  logic clk,
  input  logic res,
  input  logic i_clr,
  input  logic i_run,
  output logic o_tick
);

  logic [PRESC_WIDTH-1:0] r_presc;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_presc <= '0;
    end else if (i_clr || !i_run) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_WIDTH'(1);
    end
  end

  assign o_tick = i_run && (&r_presc[TICK_BIT:0]);

endmodule

// File: rtl/wdg_win_core.sv
// rtl/wdg_win_core.sv - windowed two-stage watchdog FSM and down-counter
module wdg_win_core
  import wdg_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int PRESC_WIDTH = 20,
  parameter int TICK_BIT    = 2
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 i_en,
  input  logic                 i_win_mode,
  input  logic [CNT_WIDTH-1:0] i_timeout,
  input  logic [CNT_WIDTH-1:0] i_window,
  input  logic                 i_kick,
  input  logic                 i_clr_s1,
  input  logic                 i_clr_s2,
  output logic                 o_irq1,
  output logic                 o_irq2,
  output logic                 o_early,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic [STATE_W-1:0]   o_state,
  output logic                 o_tick
);

  wdg_state_e           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_irq1;
  logic                 r_irq2;
  logic                 r_early;

  logic                 w_tick;
  logic                 w_expire;
  logic                 w_early;
  logic                 w_presc_clr;
  logic [CNT_WIDTH-1:0] w_reload;

  assign w_reload = (i_timeout == '0) ? CNT_WIDTH'(1) : i_timeout;
  assign w_expire = w_tick && (r_cnt == '0);
  assign w_early  = i_kick && i_win_mode && (r_cnt > i_window);

  // Prescaler restarts on every reload and on every exit from a counting state
  always_comb begin
    w_presc_clr = 1'b1;
    case (r_state)
      ST_RUN:  w_presc_clr = !i_en || i_kick || w_expire;
      ST_S1TO: w_presc_clr = !i_en || i_kick || i_clr_s1 || w_expire;
      default: w_presc_clr = 1'b1;
    endcase
  end

  wdg_presc #(
    .PRESC_WIDTH (PRESC_WIDTH),
    .TICK_BIT    (TICK_BIT)
  ) u_presc (
    .clk    (clk),
    .res    (res),
    .i_clr  (w_presc_clr),
    .i_run  (is_counting(r_state)),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_irq1  <= 1'b0;
      r_irq2  <= 1'b0;
      r_early <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_en) begin
            r_state <= ST_RUN;
            r_cnt   <= w_reload;
          end
        end
        ST_RUN: begin
          if (!i_en) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_early) begin
            r_state <= ST_S1TO;
            r_cnt   <= w_reload;
            r_irq1  <= 1'b1;
            r_early <= 1'b1;
          end else if (i_kick) begin
            r_cnt   <= w_reload;
          end else if (w_expire) begin
            r_state <= ST_S1TO;
            r_cnt   <= w_reload;
            r_irq1  <= 1'b1;
          end else if (w_tick) begin
            r_cnt   <= r_cnt - CNT_WIDTH'(1);
          end
        end
        ST_S1TO: begin
          // No window check here: any kick services the stage-1 timeout
          if (!i_en) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_irq1  <= 1'b0;
          end else if (i_clr_s1 || i_kick) begin
            r_state <= ST_RUN;
            r_cnt   <= w_reload;
            r_irq1  <= 1'b0;
            r_early <= 1'b0;
          end else if (w_expire) begin
            r_state <= ST_S2TO;
            r_irq2  <= 1'b1;
          end else if (w_tick) begin
            r_cnt   <= r_cnt - CNT_WIDTH'(1);
          end
        end
        default: begin
          if (i_clr_s2) begin
            r_irq1  <= 1'b0;
            r_irq2  <= 1'b0;
            r_early <= 1'b0;
            if (i_en) begin
              r_state <= ST_RUN;
              r_cnt   <= w_reload;
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end
        end
      endcase
    end
  end

  assign o_irq1  = r_irq1;
  assign o_irq2  = r_irq2;
  assign o_early = r_early;
  assign o_cnt   = r_cnt;
  assign o_state = r_state;
  assign o_tick  = w_tick;

endmodule

// File: doc/wdg_win_core.md
Name: wdg_win_core

Overview:
Parametrised second-generation watchdog core, instantiated behind the wdgrv register file in place of the fixed 10-bit counter/FSM pair.
- Counter and prescaler widths are parametrised.
- Adds an optional window mode: a kick before the window opens is a violation.
- Keeps the two-stage timeout: irq1 first, then irq2 if not serviced.
- Exports a sticky early-kick flag, live count and FSM state for software visibility.

Parameters:
CNT_WIDTH, 16, width of timeout down-counter and of i_timeout/i_window/o_cnt
PRESC_WIDTH, 20, width of internal prescaler counter
TICK_BIT, 2, tick period P = 2^(TICK_BIT+1) clk cycles; legal 0..PRESC_WIDTH-1

Ports:
clk  in  1  system clock, all logic on rising edge
res  in  1  reset, asynchronous, active-high
i_en  in  1  watchdog enable (level)
i_win_mode  in  1  1 = window mode active
i_timeout  in  CNT_WIDTH  reload value for both stages
i_window  in  CNT_WIDTH  window threshold; kick allowed only when cnt <= i_window
i_kick  in  1  service pulse, one cycle
i_clr_s1  in  1  software clear of stage 1 (pulse)
i_clr_s2  in  1  software clear of stage 2 (pulse)
o_irq1  out  1  stage-1 timeout / violation
o_irq2  out  1  stage-2 timeout
o_early  out  1  sticky early-kick flag
o_cnt  out  CNT_WIDTH  current down-count
o_state  out  2  FSM state
o_tick  out  1  prescaler tick, one cycle

Behaviour:
- Reset values: state IDLE; o_irq1=0, o_irq2=0, o_early=0, o_cnt=0, o_tick=0; prescaler=0.
- States: IDLE=0, RUN=1, S1TO=2, S2TO=3. o_state shows the registered state.
- Reload action: cnt <= max(i_timeout,1) and prescaler <= 0. A timeout of 0 is clamped to 1.
- Prescaler: increments every cycle in RUN and S1TO and holds 0 in IDLE/S2TO. o_tick = (presc[TICK_BIT:0] all ones) and state is RUN or S1TO. It wraps naturally.
- On tick with cnt>0: cnt decrements. On tick with cnt==0: stage transition (below).
- Timing: reload at edge k means cnt reaches 0 at edge k+T*P, and the stage transition occurs at edge k+(T+1)*P.
- IDLE:
  - i_en=1: go to RUN and reload.
  - Kick and clears are ignored; they have no effect.
- RUN:
  - i_en=0: go to IDLE with cnt=0.
  - Else, early kick (i_kick & i_win_mode & cnt > i_window): go to S1TO, reload, o_irq1=1, o_early=1.
  - Else, valid kick: reload and stay in RUN.
  - Else, tick & cnt==0: go to S1TO, reload, o_irq1=1.
- S1TO:
  - i_en=0: go to IDLE and clear o_irq1.
  - Else, i_clr_s1 or i_kick: go to RUN, reload, clear o_irq1 and o_early. In S1TO the window check does not apply.
  - Else, tick & cnt==0: go to S2TO, o_irq2=1; o_irq1 stays set.
- S2TO:
  - Terminal; i_en=0 and i_kick are ignored.
  - i_clr_s2: clear o_irq1, o_irq2 and o_early, then go to RUN with reload if i_en=1, else to IDLE.
  - i_clr_s1 alone has no effect.
- Priority within a cycle: i_en=0 > early kick > valid kick/clear > tick-expiry. A kick and an expiring tick in the same cycle means the kick wins.
- Config inputs are sampled live; a change to i_timeout takes effect at the next reload only.
- Async reset mid-count returns every register to its reset value immediately.

Decomposition:
- Package wdg_pkg:
  - state typedef/localparams (IDLE/RUN/S1TO/S2TO) and the 2-bit state width;
  - shared with the register-file glue for o_state decoding.
- One sub-module, wdg_presc: PRESC_WIDTH counter with synchronous clear and run enable; outputs the tick.
- FSM and down-counter stay in wdg_win_core.

Test Plan:
- Basic timeout (TICK_BIT=0, P=2): i_timeout=3, raise i_en at edge k, no kick -> state RUN at k; o_irq1=1 and state=S1TO at k+8; o_irq2=1 at k+16.
- Valid kick, window mode: i_timeout=10, i_window=4, kick when o_cnt=3 -> cnt reloads to 10; no irq over 30 cycles with periodic valid kicks.
- Early kick: same config, kick when o_cnt=7 -> next edge o_irq1=1, o_early=1, state=S1TO; then i_clr_s1 -> RUN, o_irq1=0, o_early=0.
- Collisions: kick coincident with expiring tick (cnt=0) in RUN -> stays RUN with cnt=i_timeout. i_clr_s1 with expiring tick in S1TO -> RUN, o_irq2 stays 0.
- S2TO stickiness: reach S2TO, drop i_en and pulse i_kick/i_clr_s1 -> irq1=irq2=1, state=3 unchanged; then i_clr_s2 with i_en=0 -> IDLE, both irqs 0.
- Async reset in S1TO mid-cycle -> all outputs 0 and state IDLE without waiting for a clk edge. Also: i_timeout=0 -> behaves as 1, giving S1TO at k+4 with P=2.
